// File: rtl/reg_file_param.sv
// reg_file_param: register file with one-cycle write pipeline and sequential clear sweep (optional REG_FILE_BYPASS_EN forwarding)
module reg_file_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  input  logic [ADDR_WIDTH-1:0] WRITEREG,
  input  logic                  WRITEENABLE,
  input  logic [ADDR_WIDTH-1:0] READREG1,
  input  logic [ADDR_WIDTH-1:0] READREG2,
  input  logic                  CLEAR,
  output logic [DATA_WIDTH-1:0] REGOUT1,
  output logic [DATA_WIDTH-1:0] REGOUT2,
  output logic                  BUSY
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic {IDLE, CLR} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  // commit pending write first, then sweep one entry or accept a new clear/write
  always_comb begin
    mem_d        = mem_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_valid_d = 1'b0;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (pend_valid_q) mem_d[pend_addr_q] = pend_data_q;
    if (state_q == CLR) begin
      mem_d[cnt_q] = '0;
      cnt_d        = cnt_q + 1'b1;
      state_d      = &cnt_q ? IDLE : CLR;
    end else if (CLEAR) begin
      state_d = CLR;
      cnt_d   = '0;
    end else if (WRITEENABLE) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = WRITEREG;
      pend_data_d  = WRITEDATA;
    end
  end
  // state registers; reset aborts any sweep or pending write
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      mem_q        <= mem_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end
  assign BUSY = (state_q == CLR);
`ifdef REG_FILE_BYPASS_EN
  assign REGOUT1 = (pend_valid_q && READREG1 == pend_addr_q) ? pend_data_q : mem_q[READREG1];
  assign REGOUT2 = (pend_valid_q && READREG2 == pend_addr_q) ? pend_data_q : mem_q[READREG2];
`else
  assign REGOUT1 = mem_q[READREG1];
  assign REGOUT2 = mem_q[READREG2];
`endif
endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed and random checks of reg_file_param against a behavioural model
module tb_reg_file_param;
  localparam int D = 8;
  logic       CLK = 1'b0, RESET = 1'b0, WRITEENABLE = 1'b0, CLEAR = 1'b0;
  logic [7:0] WRITEDATA = '0;
  logic [2:0] WRITEREG = '0, READREG1 = '0, READREG2 = '0;
  logic [7:0] REGOUT1, REGOUT2;
  logic       BUSY;
  int n_chk = 0, n_fail = 0, busy_cnt;
  logic [7:0] m [D];
  bit         pv;
  logic [2:0] pa;
  logic [7:0] pd;
  int         sweep;

  reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .CLK(CLK), .RESET(RESET), .WRITEDATA(WRITEDATA), .WRITEREG(WRITEREG),
    .WRITEENABLE(WRITEENABLE), .READREG1(READREG1), .READREG2(READREG2),
    .CLEAR(CLEAR), .REGOUT1(REGOUT1), .REGOUT2(REGOUT2), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] exp_rd(logic [2:0] a);
`ifdef REG_FILE_BYPASS_EN
    if (pv && pa == a) return pd;
`endif
    return m[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m[i] = '0;
    pv = 0;
    sweep = 0;
  endtask

  task automatic model_edge();
    if (pv) m[pa] = pd;
    pv = 0;
    if (sweep > 0) begin
      m[D - sweep] = '0;
      sweep--;
    end else if (CLEAR) sweep = D;
    else if (WRITEENABLE) begin
      pv = 1;
      pa = WRITEREG;
      pd = WRITEDATA;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, "_r1"}, 32'(REGOUT1), 32'(exp_rd(READREG1)));
    chk({tag, "_r2"}, 32'(REGOUT2), 32'(exp_rd(READREG2)));
    chk({tag, "_busy"}, 32'(BUSY), 32'(sweep > 0));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RESET) model_edge();
    #1;
  endtask

  task automatic wr(logic [2:0] a, logic [7:0] d);
    WRITEENABLE = 1'b1;
    WRITEREG = a;
    WRITEDATA = d;
    tick();
    WRITEENABLE = 1'b0;
  endtask

  task automatic chk_zero_all(string tag);
    for (int i = 0; i < D; i++) begin
      READREG1 = 3'(i);
      READREG2 = 3'(D - 1 - i);
      #1;
      chk({tag, "_r1"}, 32'(REGOUT1), 32'h0);
      chk({tag, "_r2"}, 32'(REGOUT2), 32'h0);
    end
  endtask

  task automatic wait_idle(string tag);
    for (int g = 0; g < 20 && BUSY; g++) tick();
    chk({tag, "_idle"}, 32'(BUSY), 32'h0);
  endtask

  initial begin
    model_reset();
    #2;
    chk_all("reset");
    RESET = 1'b1;
    wr(3'd5, 8'hAA);
    tick();
    READREG1 = 3'd5;
    #1;
    chk("pre_reset_r5", 32'(REGOUT1), 32'hAA);
    RESET = 1'b0;
    #1;
    model_reset();
    chk("async_reset_r5", 32'(REGOUT1), 32'h0);
    chk("async_reset_busy", 32'(BUSY), 32'h0);
    RESET = 1'b1;
    READREG1 = 3'd2;
    wr(3'd2, 8'd95);
    chk_all("wr_edge_n");
    tick();
    chk("wr_edge_n1", 32'(REGOUT1), 32'd95);
    READREG2 = 3'd4;
    wr(3'd4, 8'd6);
    wr(3'd4, 8'd15);
    chk("b2b_first", 32'(exp_rd(3'd4)), 32'(REGOUT2));
    tick();
    chk("b2b_last", 32'(REGOUT2), 32'd15);
    for (int i = 0; i < D; i++) wr(3'(i), 8'(i + 1));
    tick();
    READREG1 = 3'd7;
    READREG2 = 3'd0;
    #1;
    chk("fill_r7", 32'(REGOUT1), 32'd8);
    chk("fill_r0", 32'(REGOUT2), 32'd1);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    busy_cnt = 0;
    for (int g = 0; g < 20 && BUSY; g++) begin
      busy_cnt++;
      READREG1 = 3'(g);
      READREG2 = 3'd7;
      WRITEENABLE = (g == 2);
      WRITEREG = 3'd3;
      WRITEDATA = 8'd50;
      #1;
      chk_all("sweep");
      tick();
    end
    WRITEENABLE = 1'b0;
    chk("sweep_len", 32'(busy_cnt), 32'd8);
    chk_zero_all("after_clear");
    wr(3'd1, 8'd77);
    tick();
    WRITEENABLE = 1'b1;
    WRITEREG = 3'd1;
    WRITEDATA = 8'd28;
    CLEAR = 1'b1;
    tick();
    WRITEENABLE = 1'b0;
    CLEAR = 1'b0;
    chk("prio_busy", 32'(BUSY), 32'h1);
    wait_idle("prio");
    READREG1 = 3'd1;
    #1;
    chk("prio_r1", 32'(REGOUT1), 32'h0);
    for (int i = 0; i < D; i++) wr(3'(i), 8'(8'h40 + i));
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    #1;
    model_reset();
    chk("midsweep_busy", 32'(BUSY), 32'h0);
    chk_zero_all("midsweep");
    RESET = 1'b1;
    READREG1 = 3'd7;
    wr(3'd7, 8'd255);
    tick();
    chk("post_reset_wr", 32'(REGOUT1), 32'd255);
    for (int c = 0; c < 300; c++) begin
      WRITEENABLE = ($urandom_range(0, 1) == 1);
      CLEAR = ($urandom_range(0, 29) == 0);
      WRITEREG = 3'($urandom_range(0, 7));
      WRITEDATA = 8'($urandom_range(0, 255));
      READREG1 = 3'($urandom_range(0, 7));
      READREG2 = ($urandom_range(0, 3) == 0) ? WRITEREG : 3'($urandom_range(0, 7));
      tick();
      chk_all("rand");
    end
    WRITEENABLE = 1'b0;
    CLEAR = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each register in bits.
REQ-002 Parameter ADDR_WIDTH, default 3, register address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 CLK  input  1  single clock; all state changes on rising edge, except reset.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 WRITEDATA  input  DATA_WIDTH  write data.
REQ-006 WRITEREG  input  ADDR_WIDTH  write address.
REQ-007 WRITEENABLE  input  1  write request, sampled on rising CLK.
REQ-008 READREG1, READREG2  input  ADDR_WIDTH each  read addresses.
REQ-009 CLEAR  input  1  start a sequential clear of all registers, sampled on rising CLK.
REQ-010 REGOUT1, REGOUT2  output  DATA_WIDTH each  read data.
REQ-011 BUSY  output  1  high while a clear sweep is in progress.

Function
REQ-012 Storage: DEPTH registers of DATA_WIDTH bits; no register is hardwired.
REQ-013 Reads: combinational; REGOUTn = array[READREGn], zero latency, same-address reads on both ports allowed.
REQ-014 Write pipeline: WRITEENABLE=1 in IDLE at edge N latches {PEND_VALID=1, PEND_ADDR, PEND_DATA}; array updated at edge N+1.
REQ-015 Every edge commits a valid pending entry to the array before any new entry is latched; back-to-back writes sustain one write per cycle.
REQ-016 Edge with no accepted write sets PEND_VALID=0 after committing.
REQ-017 Consecutive writes to the same address: the later value wins.
REQ-018 FSM states IDLE, CLR; CLEAR=1 in IDLE -> CLR, counter=0, pending entry committed on that edge.
REQ-019 In CLR, each edge writes zero to array[counter] and increments counter; after writing index DEPTH-1 -> IDLE, counter wraps to 0.
REQ-020 Clear sweep occupies exactly DEPTH cycles; BUSY=1 for those DEPTH cycles, 0 otherwise.
REQ-021 In CLR, WRITEENABLE and CLEAR are ignored (writes dropped, not queued); PEND_VALID held 0.
REQ-022 WRITEENABLE and CLEAR both high in IDLE: CLEAR wins; write dropped.
REQ-023 Reads during CLR return current array contents (already-swept entries read zero).

Reset
REQ-024 RESET low immediately forces all registers to 0, PEND_VALID=0, state IDLE, counter 0, BUSY=0; REGOUT1/REGOUT2 read 0.
REQ-025 RESET low mid-sweep or with a pending write aborts it; nothing is committed.
REQ-026 After RESET rises, first edge may accept a write or CLEAR.

Configuration
REQ-027 Macro REG_FILE_BYPASS_EN defined: REGOUTn = PEND_DATA when PEND_VALID=1 and READREGn==PEND_ADDR, else array value (write visible same cycle after edge N).
REQ-028 Macro undefined: no forwarding; a read of PEND_ADDR returns the old value until edge N+1.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3)
REQ-029 Reset: RESET=0 at t0 with prior data in reg 5 -> REGOUT1 (READREG1=5)=0 immediately, BUSY=0.
REQ-030 Write/latency: write 95 to reg 2 at edge N, READREG1=2 -> 95 after edge N+1; after edge N only with REG_FILE_BYPASS_EN, else old 0.
REQ-031 Back-to-back: writes 6 then 15 to reg 4 on consecutive edges -> reg 4 = 6 then 15; READREG2=4 final 15.
REQ-032 Clear: regs 0..7 = 1..8, CLEAR pulse -> BUSY high exactly 8 cycles, all REGOUT read 0 afterwards; WRITEENABLE (reg 3, 50) during sweep -> reg 3 stays 0.
REQ-033 Priority: WRITEENABLE (reg 1, 28) and CLEAR same edge -> sweep starts, reg 1 = 0 at end.
REQ-034 Reset mid-sweep: RESET low at sweep cycle 3 -> BUSY=0 immediately, all regs 0, next write (reg 7, 255) commits normally.
